// File: rtl/mult_rr_seq_ctrl.sv
// Round-robin arbitrated, folded shift-add multiplier: one step datapath shared by NREQ requesters.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_rr_seq_ctrl #(
  parameter int unsigned N    = 4,
  parameter int unsigned M    = 4,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*N-1:0]    req_a,
  input  logic [NREQ*M-1:0]    req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [M+N-1:0]       res_p,
  output logic                 busy
);

  localparam int unsigned PW = M + N;
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [M-1:0]    mplr_q, mplr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            res_valid_d;
  logic [PW-1:0]   res_p_d;
  logic [IDW-1:0]  res_id_d;
  logic            busy_d;

  logic [N-1:0]    a_arr [NREQ];
  logic [M-1:0]    b_arr [NREQ];
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  arb_idx;
  logic [PW-1:0]   step_acc;
  logic            last_step;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*M +: M];
  end

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arb_idx = IDW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[arb_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_idx;
      end
    end
  end

  // Accept is offered only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && gnt_found)
      req_ready = NREQ'(1) << gnt_idx;
  end

  assign step_acc = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MULT_EARLY_TERM_EN
  assign last_step = (cnt_q == CW'(M - 1)) || ((mplr_q >> 1) == '0);
`else
  assign last_step = (cnt_q == CW'(M - 1));
`endif

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    res_valid_d = res_valid;
    res_p_d     = res_p;
    res_id_d    = res_id;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          mcand_d = PW'(a_arr[gnt_idx]);
          mplr_d  = b_arr[gnt_idx];
          acc_d   = '0;
          cnt_d   = '0;
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = step_acc;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_p_d     = step_acc;
          res_id_d    = id_q;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      id_q      <= '0;
      res_valid <= 1'b0;
      res_p     <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      res_valid <= res_valid_d;
      res_p     <= res_p_d;
      res_id    <= res_id_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mult_rr_seq_ctrl.sv
// Scenario bench for mult_rr_seq_ctrl; expected results queued at handshake, checked on res_valid.
module tb_mult_rr_seq_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned M    = 4;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;
  localparam int unsigned PW   = N + M;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_a;
  logic [NREQ*M-1:0]   req_b;
  logic                res_valid;
  logic                res_ready;
  logic [IDW-1:0]      res_id;
  logic [PW-1:0]       res_p;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int id; int p;} exp_t;
  exp_t sb[$];

  mult_rr_seq_ctrl #(.N(N), .M(M), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_p(res_p), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input int b);
`ifdef MULT_EARLY_TERM_EN
    int h = 0;
    for (int i = 0; i < int'(M); i++) if (b[i]) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return int'(M);
`endif
  endfunction

  task automatic set_op(input int r, input int a, input int b);
    req_a[r*N +: N] = N'(a);
    req_b[r*M +: M] = M'(b);
    req_valid[r]    = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
  endtask

  // Called on a negedge; returns when an accept is offered (handshake happens at the next posedge)
  task automatic wait_ready(output bit to, output logic [NREQ-1:0] rdy, output int hedge);
    to = 1'b1; rdy = '0; hedge = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready !== '0) begin
        rdy = req_ready; hedge = cyc + 1; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_result(output bit to, output int redge, output int id, output int p);
    to = 1'b1; redge = 0; id = -1; p = -1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (res_valid === 1'b1) begin
        id = int'(res_id); p = int'(res_p); redge = cyc; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    total++;
    if ({req_ready, res_valid, res_id, res_p, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {req_ready, res_valid, res_id, res_p, busy});
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_single();
    bit to; logic [NREQ-1:0] rdy; int hedge, redge, leak;
    exp_t e;
    res_ready = 1'b1;
    set_op(0, 15, 15);
    wait_ready(to, rdy, hedge);
    total++;
    if (to || rdy !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", rdy); end
    sb.push_back('{0, 15 * 15});
    @(negedge clk);
    leak = 0; to = 1'b1; redge = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready !== '0) leak++;
      if (res_valid === 1'b1) begin to = 1'b0; redge = cyc; break; end
      @(negedge clk);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    total++;
    if (to || int'(res_p) != e.p) begin bad++; $display("FAIL single_p got=%0d want=%0d", res_p, e.p); end
    total++;
    if (int'(res_id) != e.id) begin bad++; $display("FAIL single_id got=%0d want=%0d", res_id, e.id); end
    total++;
    if (redge - hedge != exp_lat(15)) begin
      bad++; $display("FAIL single_latency got=%0d want=%0d", redge - hedge, exp_lat(15));
    end
    total++;
    if (leak != 0) begin bad++; $display("FAIL single_ready_busy got=%0d want=0", leak); end
    req_valid[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit to; logic [NREQ-1:0] rdy; int hedge, redge, id, p, g, prev_g, prev_h, mptr;
    int ta[2]; int tb[2];
    exp_t e;
    ta = '{3, 7}; tb = '{5, 9};
    pulse_reset();
    res_ready = 1'b1;
    set_op(0, ta[0], tb[0]);
    set_op(1, ta[1], tb[1]);
    mptr = NREQ - 1; prev_g = 0; prev_h = 0;
    for (int op = 0; op < 4; op++) begin
      g = (mptr + 1) % NREQ;
      wait_ready(to, rdy, hedge);
      total++;
      if (to || rdy !== (NREQ'(1) << g)) begin
        bad++; $display("FAIL cont_grant op=%0d got=%b want=%b", op, rdy, NREQ'(1) << g);
      end
      sb.push_back('{g, ta[g] * tb[g]});
      if (op > 0) begin
        total++;
        if (hedge - prev_h != exp_lat(tb[prev_g]) + 2) begin
          bad++; $display("FAIL cont_issue_gap op=%0d got=%0d want=%0d", op, hedge - prev_h, exp_lat(tb[prev_g]) + 2);
        end
      end
      mptr = g; prev_g = g; prev_h = hedge;
      @(negedge clk);
      wait_result(to, redge, id, p);
      e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
      total++;
      if (to || id != e.id || p != e.p) begin
        bad++; $display("FAIL cont_result op=%0d got=id%0d/p%0d want=id%0d/p%0d", op, id, p, e.id, e.p);
      end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit to; logic [NREQ-1:0] rdy; int hedge, redge, id, p;
    exp_t e;
    res_ready = 1'b0;
    set_op(1, 13, 11);
    wait_ready(to, rdy, hedge);
    total++;
    if (to || rdy !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b want=10", rdy); end
    sb.push_back('{1, 13 * 11});
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_result(to, redge, id, p);
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    total++;
    if (to || id != e.id || p != e.p) begin
      bad++; $display("FAIL bp_result got=id%0d/p%0d want=id%0d/p%0d", id, p, e.id, e.p);
    end
    set_op(0, 2, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if ({res_valid, int'(res_id), int'(res_p), req_ready, busy} !== {1'b1, e.id, e.p, 2'b00, 1'b1}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=v%b id%0d p%0d rdy%b want=v1 id%0d p%0d rdy00",
                        i, res_valid, res_id, res_p, req_ready, e.id, e.p);
      end
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || req_ready !== 2'b01) begin
      bad++; $display("FAIL bp_resume got=v%b rdy%b want=v0 rdy01", res_valid, req_ready);
    end
    sb.push_back('{0, 2 * 3});
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_result(to, redge, id, p);
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    total++;
    if (to || id != e.id || p != e.p) begin
      bad++; $display("FAIL bp_next got=id%0d/p%0d want=id%0d/p%0d", id, p, e.id, e.p);
    end
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    bit to; logic [NREQ-1:0] rdy; int hedge, redge, id, p;
    exp_t e;
    set_op(0, 6, 2);
    wait_ready(to, rdy, hedge);
    sb.push_back('{0, 6 * 2});
    @(negedge clk);
    req_a[0 +: N] = N'(1);
    req_b[0 +: M] = M'(7);
    req_valid[0]  = 1'b0;
    wait_result(to, redge, id, p);
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    total++;
    if (to || id != e.id || p != e.p) begin
      bad++; $display("FAIL opchg_result got=id%0d/p%0d want=id%0d/p%0d", id, p, e.id, e.p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit to; logic [NREQ-1:0] rdy; int hedge, redge, id, p, stale;
    exp_t e;
    set_op(0, 15, 15);
    wait_ready(to, rdy, hedge);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, res_valid, res_id, res_p, busy} !== '0) begin
      bad++; $display("FAIL rmid_outputs got=%h want=0", {req_ready, res_valid, res_id, res_p, busy});
    end
    sb.delete();
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_op(1, 5, 6);
    rst_n = 1'b1;
    wait_ready(to, rdy, hedge);
    total++;
    if (to || rdy !== 2'b10 || res_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_grant got=%b v%b want=10 v0", rdy, res_valid);
    end
    sb.push_back('{1, 5 * 6});
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_result(to, redge, id, p);
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
    total++;
    if (to || id != e.id || p != e.p) begin
      bad++; $display("FAIL rmid_result got=id%0d/p%0d want=id%0d/p%0d", id, p, e.id, e.p);
    end
    stale = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (res_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL rmid_stale got=%0d want=0", stale); end
  endtask

  task automatic test_early_term();
    bit to; logic [NREQ-1:0] rdy; int hedge, redge, id, p;
    int va[4]; int vb[4];
    exp_t e;
    va = '{9, 9, 11, 0}; vb = '{1, 0, 6, 13};
    for (int t = 0; t < 4; t++) begin
      set_op(0, va[t], vb[t]);
      wait_ready(to, rdy, hedge);
      sb.push_back('{0, va[t] * vb[t]});
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_result(to, redge, id, p);
      e = (sb.size() > 0) ? sb.pop_front() : '{-1, -1};
      total++;
      if (to || p != e.p) begin bad++; $display("FAIL et_p t=%0d got=%0d want=%0d", t, p, e.p); end
      total++;
      if (redge - hedge != exp_lat(vb[t])) begin
        bad++; $display("FAIL et_latency t=%0d got=%0d want=%0d", t, redge - hedge, exp_lat(vb[t]));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_early_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_rr_seq_ctrl.md
Name: mult_rr_seq_ctrl

Overview:
- Arbitrated, folded shift-add multiplier controller: shares one iterative multiply step datapath between NREQ requesters.
- Round-robin grant, M step cycles per operation, result returned with requester ID.
- Sits between client blocks and the shift-add multiplier datapath; replaces a fully unrolled pipeline where area matters more than throughput.
- Unsigned only.

Parameters:
- N, 4, multiplicand width
- M, 4, multiplier width; step count per operation
- NREQ, 2, number of requesters (>=2)
- IDW, 1, requester ID width; must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept; at most one bit set
- req_a  in  NREQ*N  flattened multiplicands; requester i at [i*N +: N]
- req_b  in  NREQ*M  flattened multipliers; requester i at [i*M +: M]
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_id  out  IDW  index of the requester owning the result
- res_p  out  M+N  product req_a*req_b
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset values: req_ready=0, res_valid=0, res_id=0, res_p=0, busy=0. Internal registers: state=IDLE, acc=0, shifted multiplicand=0, shifted multiplier=0, step count=0, RR pointer=NREQ-1 (requester 0 has highest priority).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Arbiter scans from pointer+1 modulo NREQ and picks the first requester with req_valid=1.
  - req_ready is combinational: the picked bit only, and only in IDLE.
  - On handshake (req_valid[g]&req_ready[g]):
    - load multiplicand = req_a[g] zero-extended to M+N bits
    - load multiplier = req_b[g]; acc=0; count=0; id=g
    - pointer=g; go to RUN
  - No handshake: pointer unchanged.
- RUN, one step per cycle:
  - if multiplier[0]: acc += multiplicand, mod 2^(M+N); never overflows for unsigned inputs
  - multiplicand <<= 1; multiplier >>= 1; count++
  - after the step with count==M-1, go to DONE
- DONE:
  - res_valid=1; res_p=acc; res_id=id (all registered).
  - Hold res_p and res_id stable while res_valid&&!res_ready.
  - On res_ready: res_valid=0 and go to IDLE.
  - No new accept in the same cycle.
- Latency: handshake at clock edge t means res_valid is high after edge t+M.
- Minimum issue interval: M+2 cycles.
- A requester may drop req_valid before it is granted; the arbiter re-evaluates every IDLE cycle.
- req_a and req_b are sampled only at the handshake edge; later changes do not affect the in-flight operation.
- res_ready high while res_valid=0 has no effect.
- Asserting rst_n low at any time aborts the in-flight operation. Everything returns to reset values asynchronously; no result is produced for the aborted request.
- Operands of 0 follow the normal step count; the result is 0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN
- Defined: in RUN, if the multiplier value after this cycle's shift is zero, go to DONE after this step regardless of count.
  - Latency becomes max(1, index of highest set bit of req_b + 1) cycles from handshake to res_valid.
  - req_b=0 takes exactly 1 RUN cycle.
  - Result is identical to the full-length run.
- Undefined: fixed M RUN cycles for every operation; no zero-detect logic.

Test Plan (N=4, M=4, NREQ=2):
- Single operation: requester 0 sends a=15, b=15, res_ready=1 -> res_valid after 4 cycles, res_p=225, res_id=0; req_ready[0] high only in the accept cycle.
- Contention after reset: both valid with req0 (3,5) and req1 (7,9) -> req0 granted first, result 15 id 0; then req1, result 63 id 1. Both held valid again -> grant order 0,1,0,1.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid, res_p and res_id stay stable; req_ready stays 0 throughout; accept resumes the cycle after res_ready.
- Operand change: change req_a[0] from 6 to 1 one cycle after the handshake with b=2 -> res_p=12.
- Reset mid-operation: pull rst_n low during RUN step 2 -> all outputs 0 immediately. After release, req1 wins only if req0 is not valid; no stale result appears.
- MULT_EARLY_TERM_EN:
  - b=1, a=9 -> res_valid 1 cycle after handshake, res_p=9
  - b=0 -> 1 cycle, res_p=0
  - without the macro, both take 4 cycles with the same results
